// File: rtl/apb_reg_slave_pkg.sv
// Shared types and constants for the APB register slave.
// The optional error-response feature is controlled by APB_REG_SLAVE_PSLVERR_EN
// (see apb_reg_slave.sv).
package apb_reg_slave_pkg;

  // Transfer FSM: waiting for a setup phase, or inside an access phase.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CTR_W  = 4;

  // Data returned for a read that misses the register window.
  localparam logic [DATA_W-1:0] MISS_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: clears on a new transfer, counts while the slave
// holds off PREADY, and flags the cycle in which the next edge must raise it.
module apb_wait_ctr
  import apb_reg_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CMP_W = CTR_W + 1;

  logic [CTR_W-1:0] count_r;

  // Counter register: clear wins over enable, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CTR_W{1'b0}};
    end else if (clr) begin
      count_r <= {CTR_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + CTR_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Compare one bit wider so the +1 can never wrap into a false match.
  always_comb begin
    done = (({1'b0, count_r} + CMP_W'(1)) == CMP_W'(WAIT_CYCLES));
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: word-addressed register bank behind one PSEL bit, with
// configurable PREADY wait states.
// Optional feature macro APB_REG_SLAVE_PSLVERR_EN: when defined, misses raise
// PSLVERR and miss reads return 32'hDEAD_BEEF; when undefined, PSLVERR stays 0
// and miss reads return 0.
module apb_reg_slave
  import apb_reg_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_CYCLES = 0,
  parameter int                SEL_IDX     = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [2:0]        PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int                IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] SPAN  = 32'(4 * DEPTH);

`ifdef APB_REG_SLAVE_PSLVERR_EN
  localparam logic              ERR_EN   = 1'b1;
  localparam logic [DATA_W-1:0] MISS_VAL = MISS_RDATA;
`else
  localparam logic              ERR_EN   = 1'b0;
  localparam logic [DATA_W-1:0] MISS_VAL = 32'h0000_0000;
`endif

  state_e             state_r, state_n_s;
  logic               rdy_r, rdy_n_s;
  logic               err_r, err_n_s;
  logic [DATA_W-1:0]  rdata_r, rdata_n_s;
  logic               wr_r, wr_n_s;
  logic               hit_r, hit_n_s;
  logic [IDX_W-1:0]   idx_r, idx_n_s;

  logic               sel_s;
  logic               hit_s;
  logic [ADDR_W-1:0]  off_s;
  logic [IDX_W-1:0]   idx_s;
  logic               ctr_clr_s;
  logic               ctr_en_s;
  logic               ctr_done_s;
  logic               commit_s;

  logic [DATA_W-1:0]  bank_r [DEPTH];

  apb_wait_ctr #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_ctr (
    .clk  (HCLK),
    .rst  (HRESET),
    .clr  (ctr_clr_s),
    .en   (ctr_en_s),
    .done (ctr_done_s)
  );

  // Address decode: aligned, inside [BASE, BASE+4*DEPTH), word index from offset.
  always_comb begin
    sel_s = |(PSEL & (3'b001 << SEL_IDX));
    off_s = PADDR - BASE_ADDR;
    idx_s = off_s[IDX_W+1:2];
    hit_s = (PADDR[1:0] == 2'b00) && (PADDR >= BASE_ADDR) && (off_s < SPAN);
  end

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_n_s = state_r;
    rdy_n_s   = rdy_r;
    err_n_s   = err_r;
    rdata_n_s = rdata_r;
    wr_n_s    = wr_r;
    hit_n_s   = hit_r;
    idx_n_s   = idx_r;
    ctr_clr_s = 1'b0;
    ctr_en_s  = 1'b0;
    commit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // PENABLE high while idle is a protocol error and is ignored.
        if (sel_s && !PENABLE) begin
          wr_n_s    = PWRITE;
          hit_n_s   = hit_s;
          idx_n_s   = idx_s;
          if (PWRITE) begin
            rdata_n_s = rdata_r;
          end else if (hit_s) begin
            rdata_n_s = bank_r[idx_s];
          end else begin
            rdata_n_s = MISS_VAL;
          end
          rdy_n_s   = (WAIT_CYCLES == 0);
          err_n_s   = (WAIT_CYCLES == 0) && !hit_s && ERR_EN;
          ctr_clr_s = 1'b1;
          state_n_s = ST_ACCESS;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (rdy_r) begin
          // Completion cycle: only an in-window write touches the bank.
          commit_s  = wr_r && hit_r;
          rdy_n_s   = 1'b0;
          err_n_s   = 1'b0;
          state_n_s = ST_IDLE;
        end else if (!sel_s || !PENABLE) begin
          // Master walked away before completion: abandon without committing.
          rdy_n_s   = 1'b0;
          err_n_s   = 1'b0;
          ctr_clr_s = 1'b1;
          state_n_s = ST_IDLE;
        end else begin
          ctr_en_s = 1'b1;
          if (ctr_done_s) begin
            rdy_n_s = 1'b1;
            err_n_s = !hit_r && ERR_EN;
          end else begin
            rdy_n_s = 1'b0;
            err_n_s = 1'b0;
          end
        end
      end
      default: begin
        rdy_n_s   = 1'b0;
        err_n_s   = 1'b0;
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched transfer attributes and registered bus outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r <= ST_IDLE;
      rdy_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
      wr_r    <= 1'b0;
      hit_r   <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_n_s;
      rdy_r   <= rdy_n_s;
      err_r   <= err_n_s;
      rdata_r <= rdata_n_s;
      wr_r    <= wr_n_s;
      hit_r   <= hit_n_s;
      idx_r   <= idx_n_s;
    end
  end

  // Register bank: write data is taken from the completion cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_r[i] <= 32'h0000_0000;
      end
    end else if (commit_s) begin
      bank_r[idx_r] <= PWDATA;
    end else begin
      bank_r[idx_r] <= bank_r[idx_r];
    end
  end

  assign PRDATA  = rdata_r;
  assign PREADY  = rdy_r;
  assign PSLVERR = err_r;

endmodule
